// File: rtl/mul8u_mac_acc.sv
// Burst multiply-accumulate around an external combinational 8x8 multiplier (mul_a/mul_b -> mul_o).
// Result valid 2 edges after the last pair; in_ready stays low from the last pair until the result is taken.
module mul8u_mac_acc #(
  parameter int ACC_W = 24,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [15:0]      out_count,
  output logic             out_sat
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  state_t           state;
  logic             s1_valid, s1_last;
  logic             s2_valid, s2_last;
  logic [15:0]      prod;
  logic [15:0]      count;
  logic [ACC_W-1:0] acc;
  logic             sat_flag;
  logic             accept;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;
  logic             sat_next;

  assign in_ready = (state == ACCUM);
  assign accept   = in_valid & in_ready;

  // One extra bit exposes the carry; a clamped all-ones acc re-clamps on any nonzero add.
  assign sum      = {1'b0, acc} + {{(ACC_W-15){1'b0}}, prod};
  assign acc_next = (SAT && sum[ACC_W]) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  assign sat_next = sat_flag | sum[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      mul_a     <= 8'd0;
      mul_b     <= 8'd0;
      prod      <= 16'd0;
      count     <= 16'd0;
      acc       <= '0;
      sat_flag  <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_count <= 16'd0;
      out_sat   <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_last  <= accept & in_last;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;

      if (accept) begin
        mul_a <= in_a;
        mul_b <= in_b;
        if (count != 16'hFFFF)
          count <= count + 16'd1;
      end

      if (s1_valid)
        prod <= mul_o;

      if (s2_valid) begin
        acc      <= acc_next;
        sat_flag <= sat_next;
      end

      case (state)
        IDLE:  state <= ACCUM;
        ACCUM: if (accept && in_last) state <= DRAIN;
        DRAIN: begin
          // The last-tagged add publishes the burst result on the same edge.
          if (s2_valid && s2_last) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_acc   <= acc_next;
            out_count <= count;
            out_sat   <= sat_next;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            count     <= 16'd0;
            sat_flag  <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul8u_mac_acc.sv
// Bench for mul8u_mac_acc: three configurations share one stimulus stream and are checked against a burst-level model.
module tb_mul8u_mac_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, in_last, out_ready, approx;
  logic [7:0] in_a, in_b;

  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, sat0, sat1, sat2;
  logic [7:0]  ma0, mb0, ma1, mb1, ma2, mb2;
  logic [15:0] mo0, mo1, mo2, cnt0, cnt1, cnt2;
  logic [23:0] acc0;
  logic [15:0] acc1, acc2;

  int n_chk = 0;
  int n_fail = 0;

  // External multiplier: exact, or an operand-truncating approximate variant.
  function automatic logic [15:0] mulf(input logic [7:0] a, input logic [7:0] b, input logic ap);
    logic [15:0] wa, wb;
    wa = ap ? {8'd0, a[7:2], 2'b00} : {8'd0, a};
    wb = ap ? {8'd0, b[7:2], 2'b00} : {8'd0, b};
    return wa * wb;
  endfunction

  assign mo0 = mulf(ma0, mb0, approx);
  assign mo1 = mulf(ma1, mb1, approx);
  assign mo2 = mulf(ma2, mb2, approx);

  mul8u_mac_acc #(.ACC_W(24), .SAT(1'b1)) u_w24 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .mul_a(ma0), .mul_b(mb0), .mul_o(mo0), .out_valid(ov0),
    .out_ready(out_ready), .out_acc(acc0), .out_count(cnt0), .out_sat(sat0));

  mul8u_mac_acc #(.ACC_W(16), .SAT(1'b1)) u_w16s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .mul_a(ma1), .mul_b(mb1), .mul_o(mo1), .out_valid(ov1),
    .out_ready(out_ready), .out_acc(acc1), .out_count(cnt1), .out_sat(sat1));

  mul8u_mac_acc #(.ACC_W(16), .SAT(1'b0)) u_w16w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .mul_a(ma2), .mul_b(mb2), .mul_o(mo2), .out_valid(ov2),
    .out_ready(out_ready), .out_acc(acc2), .out_count(cnt2), .out_sat(sat2));

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Burst-level model: pairs accepted while ready, result due two edges after the last one.
  int      cw[3] = '{24, 16, 16};
  bit      cs[3] = '{1'b1, 1'b1, 1'b0};
  int      prods[$];
  int      ecyc, m_due, h_cnt, p_cnt;
  bit      m_rdy, m_ov, m_started, m_pend;
  longint  h_acc[3], p_acc[3];
  bit      h_sat[3], p_sat[3];

  task automatic model_close();
    longint v, lim;
    bit     f;
    for (int c = 0; c < 3; c++) begin
      v   = 0;
      f   = 1'b0;
      lim = longint'(1) << cw[c];
      foreach (prods[j]) begin
        v += prods[j];
        if (v >= lim) begin
          f = 1'b1;
          v = cs[c] ? lim - 1 : v - lim;
        end
      end
      p_acc[c] = v;
      p_sat[c] = f;
    end
    p_cnt = (prods.size() > 65535) ? 65535 : prods.size();
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit rdy_old, ov_old;
    if (!rst_n) begin
      m_rdy = 0; m_ov = 0; m_started = 0; m_pend = 0; ecyc = 0; m_due = 0;
      h_cnt = 0;
      for (int c = 0; c < 3; c++) begin h_acc[c] = 0; h_sat[c] = 0; end
      prods.delete();
    end else begin
      rdy_old = m_rdy;
      ov_old  = m_ov;
      ecyc++;
      if (!m_started) begin m_started = 1; m_rdy = 1; end
      if (ov_old && out_ready) begin m_ov = 0; m_rdy = 1; end
      if (m_pend && ecyc == m_due) begin
        m_ov = 1; m_pend = 0; h_cnt = p_cnt;
        for (int c = 0; c < 3; c++) begin h_acc[c] = p_acc[c]; h_sat[c] = p_sat[c]; end
      end
      if (rdy_old && in_valid) begin
        prods.push_back(int'(mulf(in_a, in_b, approx)));
        if (in_last) begin
          model_close();
          prods.delete();
          m_pend = 1; m_due = ecyc + 2; m_rdy = 0;
        end
      end
    end
  end

  task automatic cmp_inst(input int i, input logic rdy, input logic ov, input longint acc,
                          input longint cnt, input logic sat);
    chk($sformatf("cfg%0d in_ready", i), rdy, m_rdy);
    chk($sformatf("cfg%0d out_valid", i), ov, m_ov);
    chk($sformatf("cfg%0d out_acc", i), acc, h_acc[i]);
    chk($sformatf("cfg%0d out_count", i), cnt, h_cnt);
    chk($sformatf("cfg%0d out_sat", i), sat, h_sat[i]);
  endtask

  always @(negedge clk) begin
    cmp_inst(0, rdy0, ov0, acc0, cnt0, sat0);
    cmp_inst(1, rdy1, ov1, acc1, cnt1, sat1);
    cmp_inst(2, rdy2, ov2, acc2, cnt2, sat2);
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    chk("in_ready_at_send", rdy0, 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle1();
    @(posedge clk); #1;
  endtask

  // Called right after the last pair's edge k: valid must appear only after k+2.
  task automatic tail(input string name);
    @(negedge clk); chk({name, " ov_after_k"}, ov0, 0);
    @(negedge clk); chk({name, " ov_after_k1"}, ov0, 0);
    @(negedge clk); chk({name, " ov_after_k2"}, ov0, 1);
  endtask

  task automatic handshake();
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_a = 8'd0; in_b = 8'd0;
    out_ready = 1'b1; approx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", rdy0, 0);
    chk("reset mul_a", ma0, 0);
    chk("reset mul_b", mb0, 0);
    chk("reset out_valid", ov0, 0);
    chk("reset out_acc", acc0, 0);
    chk("reset out_count", cnt0, 0);
    chk("reset out_sat", sat0, 0);
    rst_n = 1'b1;
    #1 chk("in_ready before first edge", rdy0, 0);
    @(posedge clk); #1;
    chk("in_ready after first edge", rdy0, 1);

    // Back-to-back burst with exact products.
    send(8'd255, 8'd255, 1'b0);
    send(8'd1, 8'd1, 1'b0);
    send(8'd16, 8'd16, 1'b1);
    chk("mul_a holds last pair", ma0, 16);
    tail("b2b");
    chk("b2b out_acc", acc0, 65282);
    chk("b2b out_count", cnt0, 3);
    chk("b2b out_sat", sat0, 0);
    handshake();
    chk("in_ready after handshake", rdy0, 1);

    // Overflow at 16 bits: clamp vs wrap.
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    tail("ovf");
    chk("ovf sat16 out_acc", acc1, 65535);
    chk("ovf sat16 out_sat", sat1, 1);
    chk("ovf wrap16 out_acc", acc2, 64514);
    chk("ovf wrap16 out_sat", sat2, 1);
    chk("ovf w24 out_acc", acc0, 130050);
    chk("ovf w24 out_sat", sat0, 0);
    handshake();

    // Backpressure with ignored in_valid pulses.
    out_ready = 1'b0;
    send(8'd5, 8'd6, 1'b0);
    send(8'd7, 8'd8, 1'b1);
    tail("bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = (i % 2 == 0); in_a = 8'd99; in_b = 8'd99; in_last = 1'b1;
      @(negedge clk);
      chk("bp hold out_valid", ov0, 1);
      chk("bp hold out_acc", acc0, 86);
      chk("bp hold out_count", cnt0, 2);
      chk("bp in_ready low", rdy0, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    handshake();

    // Bubbles inside a burst; also shows acc restarted from zero.
    send(8'd10, 8'd10, 1'b0);
    idle1();
    idle1();
    send(8'd3, 8'd7, 1'b1);
    tail("bub");
    chk("bub out_acc", acc0, 121);
    chk("bub out_count", cnt0, 2);
    handshake();

    // Asynchronous reset mid-burst.
    send(8'd1, 8'd2, 1'b0);
    send(8'd3, 8'd4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", ov0, 0);
    chk("async rst out_acc", acc0, 0);
    chk("async rst out_count", cnt0, 0);
    chk("async rst in_ready", rdy0, 0);
    chk("async rst mul_a", ma0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'd2, 8'd3, 1'b1);
    tail("rst");
    chk("rst out_acc", acc0, 6);
    chk("rst out_count", cnt0, 1);
    handshake();

    // Approximate multiplier, random bursts with bubbles and output stalls.
    approx = 1'b1;
    for (int b = 0; b < 1000; b++) begin
      int len;
      len = $urandom_range(1, 16);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) idle1();
        send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), j == len - 1);
      end
      for (int i = 0; i < 8 && !ov0; i++) @(negedge clk);
      chk("rand out_valid arrives", ov0, 1);
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
      handshake();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
